// File: rtl/fnd_scan_ctrl.sv
// Multiplexed common-anode 7-segment scan controller with shadowed frame-boundary
// updates, leading-zero blanking, blink, PWM brightness and a dead cycle per slot.
module fnd_scan_ctrl #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int SCAN_HZ    = 1000,
  parameter int NUM_DIGITS = 4,
  parameter int PWM_BITS   = 3,
  parameter int BLINK_HZ   = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digit_hex,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    blank_lz,
  input  logic [PWM_BITS-1:0]     brightness,
  input  logic                    load,
  output logic [7:0]              fnd_data,
  output logic [NUM_DIGITS-1:0]   fnd_com,
  output logic                    frame_done
);

  localparam int SLOT       = CLK_HZ / SCAN_HZ;
  localparam int BLINK_HALF = CLK_HZ / (2 * BLINK_HZ);
  localparam int SLOT_W     = $clog2(SLOT);
  localparam int IDX_W      = $clog2(NUM_DIGITS);
  localparam int BLK_W      = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [BLK_W-1:0]  BLK_LAST  = BLK_W'(BLINK_HALF - 1);

  logic [SLOT_W-1:0]       r_slot;
  logic [IDX_W-1:0]        r_idx;
  logic [PWM_BITS-1:0]     r_pwm;
  logic [BLK_W-1:0]        r_blk_cnt;
  logic                    r_blk_ph;

  logic [4*NUM_DIGITS-1:0] r_sh_hex;
  logic [NUM_DIGITS-1:0]   r_sh_dp;
  logic [NUM_DIGITS-1:0]   r_sh_blink;
  logic                    r_sh_blz;
  logic                    r_pend;

  logic [4*NUM_DIGITS-1:0] r_act_hex;
  logic [NUM_DIGITS-1:0]   r_act_dp;
  logic [NUM_DIGITS-1:0]   r_act_blink;
  logic                    r_act_blz;

  logic [7:0]              r_data;
  logic [NUM_DIGITS-1:0]   r_com;
  logic                    r_frame_done;

  logic                    w_slot_wrap;
  logic                    w_frame_wrap;
  logic [3:0]              w_nib;
  logic                    w_hi_nz;
  logic                    w_blanked;
  logic                    w_drive;
  logic [6:0]              w_seg;
  logic [NUM_DIGITS-1:0]   w_com_on;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      4'hF:    seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
    return seg;
  endfunction

  assign w_slot_wrap  = (r_slot == SLOT_LAST);
  assign w_frame_wrap = w_slot_wrap && (r_idx == IDX_LAST);
  assign w_nib        = r_act_hex[{r_idx, 2'b00} +: 4];

  // Per-slot drive decision: a digit is blanked when it and all digits above it are zero.
  always_comb begin
    w_hi_nz = 1'b0;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      w_hi_nz = w_hi_nz | ((j >= int'(r_idx)) && (r_act_hex[4*j +: 4] != 4'h0));
    end
    w_blanked = r_act_blz && (r_idx != IDX_W'(0)) && !w_hi_nz;
    w_drive   = (r_slot != SLOT_W'(0)) && (r_pwm <= brightness) && !w_blanked
                && !(r_act_blink[r_idx] && r_blk_ph);
    w_seg     = hex_to_seg(w_nib);
    w_com_on  = ~(NUM_DIGITS'(1) << r_idx);
  end

  // Slot, digit, PWM and blink timebases; all free-running from reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_slot    <= SLOT_W'(0);
      r_idx     <= IDX_W'(0);
      r_pwm     <= PWM_BITS'(0);
      r_blk_cnt <= BLK_W'(0);
      r_blk_ph  <= 1'b0;
    end else begin
      r_pwm <= r_pwm + PWM_BITS'(1);
      if (w_slot_wrap) begin
        r_slot <= SLOT_W'(0);
        r_idx  <= (r_idx == IDX_LAST) ? IDX_W'(0) : r_idx + IDX_W'(1);
      end else begin
        r_slot <= r_slot + SLOT_W'(1);
      end
      if (r_blk_cnt == BLK_LAST) begin
        r_blk_cnt <= BLK_W'(0);
        r_blk_ph  <= ~r_blk_ph;
      end else begin
        r_blk_cnt <= r_blk_cnt + BLK_W'(1);
      end
    end
  end

  // Shadow capture on load; a pending shadow becomes active only at the frame wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sh_hex    <= '0;
      r_sh_dp     <= '0;
      r_sh_blink  <= '0;
      r_sh_blz    <= 1'b0;
      r_pend      <= 1'b0;
      r_act_hex   <= '0;
      r_act_dp    <= '0;
      r_act_blink <= '0;
      r_act_blz   <= 1'b0;
    end else begin
      if (w_frame_wrap && r_pend) begin
        r_act_hex   <= r_sh_hex;
        r_act_dp    <= r_sh_dp;
        r_act_blink <= r_sh_blink;
        r_act_blz   <= r_sh_blz;
      end
      if (load) begin
        r_sh_hex   <= digit_hex;
        r_sh_dp    <= dp_mask;
        r_sh_blink <= blink_mask;
        r_sh_blz   <= blank_lz;
        r_pend     <= 1'b1;
      end else if (w_frame_wrap) begin
        r_pend <= 1'b0;
      end
    end
  end

  // Registered pin drivers, one cycle behind the timebase state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data       <= 8'hFF;
      r_com        <= {NUM_DIGITS{1'b1}};
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_frame_wrap;
      if (w_drive) begin
        r_data <= {~r_act_dp[r_idx], w_seg};
        r_com  <= w_com_on;
      end else begin
        r_data <= 8'hFF;
        r_com  <= {NUM_DIGITS{1'b1}};
      end
    end
  end

  assign fnd_data   = r_data;
  assign fnd_com    = r_com;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Self-checking bench for fnd_scan_ctrl: time-arithmetic reference model checked
// every cycle, a table of display vectors, and hand-written corner sequences.
module tb_fnd_scan_ctrl;

  localparam int ND    = 4;
  localparam int SLOT  = 8;
  localparam int FRAME = SLOT * ND;
  localparam int HALF  = 40;
  localparam int PWM_N = 8;
  localparam int NV    = 7;

  logic        clk        = 1'b0;
  logic        reset      = 1'b1;
  logic [15:0] digit_hex  = 16'h0;
  logic [3:0]  dp_mask    = 4'h0;
  logic [3:0]  blink_mask = 4'h0;
  logic        blank_lz   = 1'b0;
  logic [2:0]  brightness = 3'd7;
  logic        load       = 1'b0;
  logic [7:0]  fnd_data;
  logic [3:0]  fnd_com;
  logic        frame_done;

  fnd_scan_ctrl #(
    .CLK_HZ(80), .SCAN_HZ(10), .NUM_DIGITS(ND), .PWM_BITS(3), .BLINK_HZ(1)
  ) dut (
    .clk(clk), .reset(reset), .digit_hex(digit_hex), .dp_mask(dp_mask),
    .blink_mask(blink_mask), .blank_lz(blank_lz), .brightness(brightness),
    .load(load), .fnd_data(fnd_data), .fnd_com(fnd_com), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0]     hex;
    logic [3:0]      dp;
    logic            blz;
    logic [3:0][7:0] exp;
  } vec_t;

  vec_t        vec [NV];
  logic [7:0]  seg8 [16];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          t        = 0;
  int          lit0, lit1, n_lit;

  logic [15:0] m_hex, sh_hex;
  logic [3:0]  m_dp, m_blink, sh_dp, sh_blink;
  logic        m_blz, sh_blz, m_pend;
  logic [7:0]  obs_data [ND];
  logic [3:0]  obs_com  [ND];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0d)", nm, act, exp, t);
    end
  endtask

  task automatic model_reset();
    t = 0;
    m_hex = 16'h0; m_dp = 4'h0; m_blink = 4'h0; m_blz = 1'b0;
    sh_hex = 16'h0; sh_dp = 4'h0; sh_blink = 4'h0; sh_blz = 1'b0; m_pend = 1'b0;
  endtask

  // Expected pins for timebase instant tt, from slot/digit/PWM/blink arithmetic.
  function automatic void model_out(input int tt, output logic [7:0] d, output logic [3:0] c);
    int slot, idx, p, ph;
    logic [15:0] upper;
    logic [3:0]  nib;
    bit on;
    slot  = tt % SLOT;
    idx   = (tt / SLOT) % ND;
    p     = tt % PWM_N;
    ph    = (tt / HALF) % 2;
    upper = m_hex >> (4 * idx);
    nib   = upper[3:0];
    on = (slot != 0) && (p <= int'(brightness))
         && !(m_blz && idx >= 1 && upper == 16'h0)
         && !(m_blink[idx] && ph == 1);
    if (on) begin
      d = {~m_dp[idx], seg8[nib][6:0]};
      c = ~(4'b0001 << idx);
    end else begin
      d = 8'hFF;
      c = 4'hF;
    end
  endfunction

  task automatic tick();
    logic [7:0] ed;
    logic [3:0] ec;
    logic ef;
    int tp;
    @(posedge clk);
    tp = t;
    model_out(tp, ed, ec);
    ef = ((tp % FRAME) == FRAME - 1);
    if (ef && m_pend) begin
      m_hex = sh_hex; m_dp = sh_dp; m_blink = sh_blink; m_blz = sh_blz; m_pend = 1'b0;
    end
    if (load) begin
      sh_hex = digit_hex; sh_dp = dp_mask; sh_blink = blink_mask; sh_blz = blank_lz;
      m_pend = 1'b1;
    end
    t = t + 1;
    #1;
    chk("fnd_data", 32'(fnd_data), 32'(ed));
    chk("fnd_com", 32'(fnd_com), 32'(ec));
    chk("frame_done", 32'(frame_done), 32'(ef));
    chk("com_onehot", 32'($countones(~fnd_com) <= 1), 32'd1);
    if (tp % SLOT == 4) begin
      obs_data[(tp / SLOT) % ND] = fnd_data;
      obs_com[(tp / SLOT) % ND]  = fnd_com;
    end
    if (!fnd_com[0]) lit0++;
    if (!fnd_com[1]) lit1++;
    if (fnd_com != 4'hF) n_lit++;
  endtask

  task automatic do_load(input logic [15:0] h, input logic [3:0] dp, input logic [3:0] bm,
                         input logic bz);
    digit_hex = h; dp_mask = dp; blink_mask = bm; blank_lz = bz; load = 1'b1;
    tick();
    load = 1'b0;
    digit_hex = 16'($urandom); dp_mask = 4'($urandom);
    blink_mask = 4'($urandom); blank_lz = 1'($urandom);
  endtask

  task automatic wait_to(input int md, input int ph);
    for (int k = 0; k < md && (t % md) != ph; k++) tick();
  endtask

  task automatic chk_frame(input string nm, input logic [3:0][7:0] exp);
    logic [3:0] ec;
    for (int i = 0; i < ND; i++) begin
      ec = (exp[i] == 8'hFF) ? 4'hF : ~(4'b0001 << i);
      chk({nm, "_data"}, 32'(obs_data[i]), 32'(exp[i]));
      chk({nm, "_com"}, 32'(obs_com[i]), 32'(ec));
    end
  endtask

  initial begin
    seg8 = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    vec[0] = '{16'h1234, 4'b0100, 1'b0, {8'hF9, 8'h24, 8'hB0, 8'h99}};
    vec[1] = '{16'h0070, 4'b0000, 1'b1, {8'hFF, 8'hFF, 8'hF8, 8'hC0}};
    vec[2] = '{16'h0000, 4'b0000, 1'b1, {8'hFF, 8'hFF, 8'hFF, 8'hC0}};
    vec[3] = '{16'hABCD, 4'b0000, 1'b0, {8'h88, 8'h83, 8'hC6, 8'hA1}};
    vec[4] = '{16'h0000, 4'b0000, 1'b0, {8'hC0, 8'hC0, 8'hC0, 8'hC0}};
    vec[5] = '{16'h0105, 4'b1000, 1'b1, {8'hFF, 8'hF9, 8'hC0, 8'h92}};
    vec[6] = '{16'h8F00, 4'b0011, 1'b1, {8'h80, 8'h8E, 8'h40, 8'h40}};
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    chk("rst_data", 32'(fnd_data), 32'h0000_00FF);
    chk("rst_com", 32'(fnd_com), 32'h0000_000F);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    reset = 1'b0;

    for (int r = 0; r < NV; r++) begin
      brightness = 3'd7;
      wait_to(FRAME, 5);
      do_load(vec[r].hex, vec[r].dp, 4'h0, vec[r].blz);
      wait_to(FRAME, 0);
      repeat (FRAME) tick();
      chk_frame("table", vec[r].exp);
    end

    // Tear-free update: a load mid-frame leaves the rest of that frame untouched.
    wait_to(FRAME, 5);
    do_load(16'h1234, 4'b0100, 4'h0, 1'b0);
    wait_to(FRAME, 0);
    wait_to(FRAME, 12);
    do_load(16'hABCD, 4'h0, 4'h0, 1'b0);
    wait_to(FRAME, 0);
    chk("tear_d1", 32'(obs_data[1]), 32'h0000_00B0);
    chk("tear_d2", 32'(obs_data[2]), 32'h0000_0024);
    chk("tear_d3", 32'(obs_data[3]), 32'h0000_00F9);
    repeat (FRAME) tick();
    chk_frame("tear_next", {8'h88, 8'h83, 8'hC6, 8'hA1});

    // PWM duty: lit cycles per frame = 4 digits * brightness (p=0 is the dead cycle).
    for (int b = 0; b < 8; b++) begin
      brightness = 3'(b);
      wait_to(FRAME, 0);
      n_lit = 0;
      repeat (FRAME) tick();
      chk("pwm_lit", 32'(n_lit), 32'(4 * b));
    end
    brightness = 3'd7;

    // Blink on digit 0 only; other digits unaffected.
    do_load(16'h1234, 4'h0, 4'b0001, 1'b0);
    repeat (40) tick();
    wait_to(160, 0);
    lit0 = 0;
    lit1 = 0;
    repeat (160) tick();
    chk("blink_d0", 32'(lit0), 32'd21);
    chk("blink_d1", 32'(lit1), 32'd35);

    // Load coincident with the wrap takes effect one frame later.
    wait_to(FRAME, 31);
    do_load(16'h5555, 4'h0, 4'h0, 1'b0);
    repeat (FRAME) tick();
    chk("wrap_load_old", 32'(obs_data[1]), 32'h0000_00B0);
    repeat (FRAME) tick();
    chk("wrap_load_new", 32'(obs_data[1]), 32'h0000_0092);

    // Asynchronous reset during digit 2 with a load still pending.
    wait_to(FRAME, 19);
    do_load(16'h9999, 4'hF, 4'h0, 1'b1);
    reset = 1'b1;
    #1;
    chk("async_rst_data", 32'(fnd_data), 32'h0000_00FF);
    chk("async_rst_com", 32'(fnd_com), 32'h0000_000F);
    chk("async_rst_fd", 32'(frame_done), 32'd0);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (FRAME) tick();
    chk_frame("post_rst", {8'hC0, 8'hC0, 8'hC0, 8'hC0});
    repeat (FRAME) tick();
    chk_frame("post_rst2", {8'hC0, 8'hC0, 8'hC0, 8'hC0});

    // Randomized loads, masks and brightness against the model.
    for (int k = 0; k < 60; k++) begin
      brightness = 3'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        do_load(16'($urandom) >> (4 * $urandom_range(0, 4)), 4'($urandom),
                4'($urandom), 1'($urandom));
      end
      repeat ($urandom_range(1, 40)) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at t=%0d", t);
    $fatal(1, "watchdog");
  end

endmodule
